// File: rtl/embed_pool_pkg.sv
// embed_pool_pkg: shared types and constants for the embedding mean-pool block.
//   state_t    - pool FSM states
//   DEF_RECIP  - default reciprocal floor(2^DEF_SHIFT / 15)
//   DEF_SHIFT  - fraction bits of the reciprocal
//   acc_width  - signed accumulator width that cannot overflow over 'rows' adds
package embed_pool_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

  localparam int DEF_RECIP = 1092;
  localparam int DEF_SHIFT = 14;

  function automatic int acc_width(input int dw, input int rows);
    return dw + $clog2(rows);
  endfunction

endpackage

// File: rtl/embed_mean_scale.sv
// embed_mean_scale: combinational per-feature mean.
//   acc  in  signed [ACC_WIDTH]  column sum over all rows
//   mean out signed [DATA_WIDTH] round-half-up(acc * RECIP / 2^SHIFT), saturated
module embed_mean_scale #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 12,
  parameter int RECIP      = 1092,
  parameter int SHIFT      = 14
)(
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] mean
);
  localparam int PW = ACC_WIDTH + $clog2(RECIP + 1) + 1;

  localparam logic signed [PW-1:0] RECIP_P = PW'(RECIP);
  localparam logic signed [PW-1:0] RND     = PW'(2 ** (SHIFT - 1));
  localparam logic signed [PW-1:0] MAXV    = PW'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [PW-1:0] MINV    = -PW'(2 ** (DATA_WIDTH - 1));

  logic signed [PW-1:0] acc_x, p, m;

  assign acc_x = PW'(acc);          // sign-extends: acc is signed
  assign p     = acc_x * RECIP_P + RND;
  assign m     = p >>> SHIFT;       // floor, so +RND gives round-half-up

  always_comb begin
    mean = DATA_WIDTH'(m);
    if (m > MAXV)      mean = DATA_WIDTH'(MAXV);
    else if (m < MINV) mean = DATA_WIDTH'(MINV);
  end

endmodule

// File: rtl/embed_mean_pool.sv
// embed_mean_pool: averages each feature column of a captured embedding
// matrix over its rows, one row per cycle, and presents the rounded,
// saturated mean vector.
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  matrix handshake (ready only in IDLE)
//   data_in            MATRIX_SIZE_1 x MATRIX_SIZE_2 signed matrix
//   out_valid/out_ready mean-vector handshake
//   data_out           MATRIX_SIZE_2 signed means, held until accepted
module embed_mean_pool
  import embed_pool_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MATRIX_SIZE_1 = 15,
  parameter int MATRIX_SIZE_2 = 16,
  parameter int RECIP         = DEF_RECIP,
  parameter int SHIFT         = DEF_SHIFT
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] data_in [0:MATRIX_SIZE_1-1][0:MATRIX_SIZE_2-1],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] data_out [0:MATRIX_SIZE_2-1]
);
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, MATRIX_SIZE_1);
  localparam int ROW_W     = (MATRIX_SIZE_1 > 1) ? $clog2(MATRIX_SIZE_1) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MATRIX_SIZE_1 - 1);

  state_t                        state;
  logic [ROW_W-1:0]              row;
  logic signed [DATA_WIDTH-1:0]  mbuf [0:MATRIX_SIZE_1-1][0:MATRIX_SIZE_2-1];
  logic signed [ACC_WIDTH-1:0]   acc  [0:MATRIX_SIZE_2-1];
  logic signed [DATA_WIDTH-1:0]  mean [0:MATRIX_SIZE_2-1];

  assign in_ready = (state == IDLE) && !rst;

  for (genvar j = 0; j < MATRIX_SIZE_2; j++) begin : g_scale
    embed_mean_scale #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .RECIP      (RECIP),
      .SHIFT      (SHIFT)
    ) u_scale (
      .acc  (acc[j]),
      .mean (mean[j])
    );
  end

  // mbuf is deliberately not reset: it is always overwritten on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      out_valid <= 1'b0;
      for (int j = 0; j < MATRIX_SIZE_2; j++) begin
        acc[j]      <= '0;
        data_out[j] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // in_ready is just (state==IDLE) here since rst is low
          if (in_valid) begin
            mbuf  <= data_in;
            row   <= '0;
            state <= ACCUM;
            for (int j = 0; j < MATRIX_SIZE_2; j++) acc[j] <= '0;
          end
        end
        ACCUM: begin
          for (int j = 0; j < MATRIX_SIZE_2; j++)
            acc[j] <= acc[j] + ACC_WIDTH'(mbuf[row][j]);
          if (row == LAST_ROW) begin
            row   <= '0;
            state <= SCALE;
          end else begin
            row <= row + 1'b1;
          end
        end
        SCALE: begin
          data_out  <= mean;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
